// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with memory via req/ready and traps on illegal encodings or bus timeout.
module multicycle_control_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       toggle_equal,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       retire,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
        S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_RTEXE = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP = 4'd12, S_JAL = 4'd13, S_JR = 4'd14, S_TRAP = 4'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        // Counter is zero outside a stalled access, so entering a mem state starts from 0.
        wait_d    = (mem_req && !mem_ready) ? wait_q + CW'(1) : '0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    6'b000000: begin
                        if (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                            state_d = S_RTEXE;
                        else if (funct == 6'b001000)
                            state_d = S_JR;
                        else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000100, 6'b000101: state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    6'b000011:            state_d = S_JAL;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEXE:  state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        // A ready arriving in the final allowed cycle beats the timeout.
        if (TIMEOUT != 0 && mem_req && !mem_ready && wait_q == WAIT_LAST) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        toggle_equal = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_control  = 3'b000;
        reg_write    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            S_RTEXE: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_control  = 3'b110;
                pc_src       = 2'b01;
                branch       = 1'b1;
                toggle_equal = (op == 6'b000101);
                retire       = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                retire     = 1'b1;
            end
            S_JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
endmodule
